// File: rtl/dpc_manual_list_matcher.sv
// dpc_manual_list_matcher
// Walks a raster-sorted list of user-supplied bad-pixel coordinates, stored in
// an internal RAM, against the incoming pixel stream. A two-entry prefetch
// queue sustains one match per cycle, including horizontally adjacent entries.
//
// Optional feature macro: DPC_LIST_SKIP_EN
//   defined   : a list head that is raster-behind the scan is popped and counted
//   undefined : a behind head is held and the list stalls for the frame
//
// Ports
//   clk, rst         sole clock, synchronous active-high reset
//   frame_start      one-cycle pulse per frame, before the first pixel
//   pix_valid/x/y    pixel coordinate stream
//   bad_point_num    valid list entries, sampled at frame_start
//   wen_lut/waddr_lut/wdata_lut  list write port ({x[31:16], y[15:0]})
//   bad_pixel_match  current pixel is listed (combinational)
//   match_idx        list index of the matched entry
//   list_ready       prefetch queue primed for this frame
//   list_done        all entries of this frame consumed
//   match_cnt        matches this frame (saturating)
//   skip_cnt         entries skipped this frame (saturating)
module dpc_manual_list_matcher #(
  parameter int unsigned WIDTH_BITS  = 10,
  parameter int unsigned HEIGHT_BITS = 10,
  parameter int unsigned MAX_DP_NUM  = 128,
  parameter int unsigned MAX_DP_BIT  = 7,
  parameter int unsigned CNT_BITS    = MAX_DP_BIT + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   pix_valid,
  input  logic [WIDTH_BITS-1:0]  pix_x,
  input  logic [HEIGHT_BITS-1:0] pix_y,
  input  logic [MAX_DP_BIT:0]    bad_point_num,
  input  logic                   wen_lut,
  input  logic [MAX_DP_BIT-1:0]  waddr_lut,
  input  logic [31:0]            wdata_lut,
  output logic                   bad_pixel_match,
  output logic [MAX_DP_BIT-1:0]  match_idx,
  output logic                   list_ready,
  output logic                   list_done,
  output logic [CNT_BITS-1:0]    match_cnt,
  output logic [CNT_BITS-1:0]    skip_cnt
);

  localparam int unsigned         XY_W       = WIDTH_BITS + HEIGHT_BITS;
  localparam int unsigned         ENT_W      = XY_W + MAX_DP_BIT;
  localparam logic [MAX_DP_BIT:0] LP_MAX_N   = (MAX_DP_BIT + 1)'(MAX_DP_NUM);
  localparam logic [CNT_BITS-1:0] LP_CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                r_state, w_state_nx;
  logic [XY_W-1:0]       r_mem [MAX_DP_NUM];
  logic [XY_W-1:0]       r_rdata;
  logic [MAX_DP_BIT-1:0] r_rdata_idx;
  logic                  r_inflight;      // r_rdata holds a fresh entry this cycle
  logic [MAX_DP_BIT:0]   r_rd_ptr, r_n;
  logic [ENT_W-1:0]      r_q [2];         // r_q[0] is the head
  logic [1:0]            r_occ;
  logic [CNT_BITS-1:0]   r_match_cnt;

  logic [WIDTH_BITS-1:0]  w_hx;
  logic [HEIGHT_BITS-1:0] w_hy;
  logic [MAX_DP_BIT-1:0]  w_hidx, w_rd_addr;
  logic [MAX_DP_BIT:0]    w_n_in, w_rdptr_nx;
  logic [1:0]             w_occ_mid, w_occ_nx;
  logic                   w_cmp_en, w_eq, w_skip, w_pop, w_issue;
  logic                   w_drained, w_primed;
  logic                   w_unused;

  // Only the low coordinate bits of each entry half are kept.
  assign w_unused = ^{wdata_lut[31:16+WIDTH_BITS], wdata_lut[15:HEIGHT_BITS]};

  assign w_hx      = r_q[0][ENT_W-1 -: WIDTH_BITS];
  assign w_hy      = r_q[0][MAX_DP_BIT +: HEIGHT_BITS];
  assign w_hidx    = r_q[0][MAX_DP_BIT-1:0];
  assign w_rd_addr = r_rd_ptr[MAX_DP_BIT-1:0];
  assign w_n_in    = (bad_point_num > LP_MAX_N) ? LP_MAX_N : bad_point_num;

  // frame_start wins over a coincident pixel.
  assign w_cmp_en = pix_valid && !frame_start && (r_occ != 2'd0);
  assign w_eq     = w_cmp_en && (w_hx == pix_x) && (w_hy == pix_y);

`ifdef DPC_LIST_SKIP_EN
  logic                w_behind;
  logic [CNT_BITS-1:0] r_skip_cnt;

  assign w_behind = w_cmp_en && ((w_hy < pix_y) || ((w_hy == pix_y) && (w_hx < pix_x)));
  assign w_skip   = w_behind;
  assign skip_cnt = r_skip_cnt;

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      r_skip_cnt <= '0;
    end else if (w_skip && (r_skip_cnt != LP_CNT_MAX)) begin
      r_skip_cnt <= r_skip_cnt + CNT_BITS'(1);
    end
  end
`else
  assign w_skip   = 1'b0;
  assign skip_cnt = '0;
`endif

  assign w_pop = w_eq || w_skip;

  // Occupancy after this cycle's pop and push; a read is issued only if its
  // data will find a free slot when it returns next cycle.
  always_comb begin
    w_occ_mid  = r_occ - {1'b0, w_pop};
    w_occ_nx   = w_occ_mid + {1'b0, r_inflight};
    w_issue    = !frame_start && (r_rd_ptr < r_n) && (w_occ_nx < 2'd2);
    w_rdptr_nx = w_issue ? (r_rd_ptr + (MAX_DP_BIT + 1)'(1)) : r_rd_ptr;
  end

  // Decisions use next-cycle occupancy/in-flight so the state tracks the
  // queue without an extra cycle of lag.
  always_comb begin
    w_drained  = (w_rdptr_nx == r_n) && !w_issue && (w_occ_nx == 2'd0);
    w_primed   = (w_occ_nx == 2'd2) || ((w_occ_nx == 2'd1) && w_issue) ||
                 ((w_rdptr_nx == r_n) && !w_issue);
    w_state_nx = r_state;
    case (r_state)
      S_LOAD:  if (w_drained) w_state_nx = S_DONE;
               else if (w_primed) w_state_nx = S_RUN;
      S_RUN:   if (w_drained) w_state_nx = S_DONE;
      default: w_state_nx = r_state;
    endcase
    if (frame_start) w_state_nx = S_LOAD;
  end

  always_ff @(posedge clk) begin
    if (wen_lut && ({1'b0, waddr_lut} < LP_MAX_N)) begin
      r_mem[waddr_lut] <= {wdata_lut[16 +: WIDTH_BITS], wdata_lut[0 +: HEIGHT_BITS]};
    end
    if (w_issue) begin
      r_rdata     <= r_mem[w_rd_addr];
      r_rdata_idx <= w_rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_q[0] <= r_q[1];
    // Returning entry lands behind whatever survives the pop.
    if (r_inflight) r_q[w_occ_mid[0]] <= {r_rdata, r_rdata_idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_occ       <= '0;
      r_inflight  <= 1'b0;
      r_rd_ptr    <= '0;
      r_n         <= '0;
      r_match_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (frame_start) begin
        r_occ       <= '0;
        r_inflight  <= 1'b0;
        r_rd_ptr    <= '0;
        r_n         <= w_n_in;
        r_match_cnt <= '0;
      end else begin
        r_occ      <= w_occ_nx;
        r_inflight <= w_issue;
        r_rd_ptr   <= w_rdptr_nx;
        if (w_eq && (r_match_cnt != LP_CNT_MAX)) r_match_cnt <= r_match_cnt + CNT_BITS'(1);
      end
    end
  end

  assign bad_pixel_match = w_eq;
  assign match_idx       = w_eq ? w_hidx : '0;
  assign list_ready      = (r_state == S_RUN);
  assign list_done       = (r_state == S_DONE);
  assign match_cnt       = r_match_cnt;

endmodule
